// File: rtl/xbar_pkg.sv
// Shared crossbar types: payload width, flit layout and master ids.
package xbar_pkg;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic             dst;
        logic [WIDTH-1:0] data;
    } flit_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/xbar_ingress_fifo_if.sv
// val/rdy flit channel; the master drives the word, the slave drives rdy.
interface xbar_ingress_fifo_if #(
    parameter int WIDTH = xbar_pkg::WIDTH
);
    logic             val;
    logic             dst;
    logic [WIDTH-1:0] data;
    logic             rdy;

    modport master (output val, output dst, output data, input rdy);
    modport slave  (input val, input dst, input data, output rdy);

endinterface

// File: rtl/xbar_fifo_ctrl.sv
// Pointer pair with wrap bit: derives full/empty/count and qualifies push/pop.
module xbar_fifo_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_val,
    input  logic                     out_rdy,
    output logic                     push,
    output logic                     pop,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     in_rdy,
    output logic                     out_val
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    // Status comes only from the registered pointers, never from in_val/out_rdy.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count   = wr_ptr_q - rd_ptr_q;
        in_rdy  = !full && rst_n;
        out_val = !empty;
        push    = in_val && in_rdy;
        pop     = out_val && out_rdy;
        wr_idx  = wr_ptr_q[AW-1:0];
        rd_idx  = rd_ptr_q[AW-1:0];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (!rst_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
    end

endmodule

// File: rtl/xbar_ingress_fifo.sv
// Per-source ingress queue ahead of the crossbar; head is read straight
// from the register array so a stored word is visible the cycle after push.
module xbar_ingress_fifo #(
    parameter int WIDTH = xbar_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xbar_ingress_fifo_if.slave     in_if,
    xbar_ingress_fifo_if.master    out_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    import xbar_pkg::*;

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic             dst;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic          push;
    logic          pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          in_rdy;
    logic          out_val;

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    xbar_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (in_if.val),
        .out_rdy (out_if.rdy),
        .push    (push),
        .pop     (pop),
        .wr_idx  (wr_idx),
        .rd_idx  (rd_idx),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .in_rdy  (in_rdy),
        .out_val (out_val)
    );

    // Storage is not reset; the pointers alone define what is valid.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_idx].dst  = in_if.dst;
            mem_d[wr_idx].data = in_if.data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_if.rdy   = in_rdy;
    assign out_if.val  = out_val;
    assign out_if.dst  = mem_q[rd_idx].dst;
    assign out_if.data = mem_q[rd_idx].data;

endmodule

// File: tb/tb_xbar_ingress_fifo.sv
// Directed and random stimulus against a queue model of the ingress FIFO.
module tb_xbar_ingress_fifo;
    import xbar_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    xbar_ingress_fifo_if #(.WIDTH(W)) in_if ();
    xbar_ingress_fifo_if #(.WIDTH(W)) out_if ();

    xbar_ingress_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (in_if.slave),
        .out_if (out_if.master),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    flit_t q[$];
    int    total  = 0;
    int    passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle, check visible state before the edge, then update model.
    task automatic step(input logic v, input logic dst,
                        input logic [W-1:0] dat, input logic r,
                        input logic rst);
        bit do_push;
        bit do_pop;
        flit_t f;
        in_if.val  = v;
        in_if.dst  = dst;
        in_if.data = dat;
        out_if.rdy = r;
        rst_n      = rst;
        @(negedge clk);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == D));
        chk("out_val", 32'(out_if.val), 32'(q.size() != 0));
        chk("in_rdy", 32'(in_if.rdy), 32'(rst && q.size() < D));
        if (q.size() != 0) begin
            chk("out_dst", 32'(out_if.dst), 32'(q[0].dst));
            chk("out_data", 32'(out_if.data), 32'(q[0].data));
        end
        do_push = v && rst && (q.size() < D);
        do_pop  = (q.size() != 0) && r;
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                f.dst  = dst;
                f.data = dat;
                q.push_back(f);
            end
        end
    endtask

    initial begin
        logic          hv;
        logic          hd;
        logic [W-1:0]  hdata;
        logic          rr;
        logic          rs;

        in_if.val  = 1'b0;
        in_if.dst  = M0;
        in_if.data = '0;
        out_if.rdy = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();

        // reset state, then release
        step(1'b0, M0, 8'h00, 1'b0, 1'b0);
        step(1'b0, M0, 8'h00, 1'b0, 1'b1);

        // single word held then popped
        step(1'b1, M1, 8'h2A, 1'b0, 1'b1);
        repeat (3) step(1'b0, M0, 8'h00, 1'b0, 1'b1);
        step(1'b0, M0, 8'h00, 1'b1, 1'b1);
        step(1'b0, M0, 8'h00, 1'b0, 1'b1);

        // fill, refused 5th, push+pop at full, drain
        for (int i = 1; i <= 4; i++)
            step(1'b1, i[0], W'(i), 1'b0, 1'b1);
        step(1'b1, M1, 8'h05, 1'b0, 1'b1);
        step(1'b1, M1, 8'h05, 1'b1, 1'b1);
        step(1'b1, M1, 8'h05, 1'b0, 1'b1);
        repeat (5) step(1'b0, M0, 8'h00, 1'b1, 1'b1);

        // streaming across pointer wrap
        for (int i = 0; i < 10; i++)
            step(1'b1, i[1], W'(i), 1'b1, 1'b1);
        repeat (2) step(1'b0, M0, 8'h00, 1'b1, 1'b1);

        // reset mid-stream then 0x55 emerges first
        for (int i = 0; i < 3; i++)
            step(1'b1, M0, W'(8'h60 + i), 1'b0, 1'b1);
        step(1'b1, M0, 8'h77, 1'b0, 1'b0);
        step(1'b1, M1, 8'h55, 1'b0, 1'b1);
        step(1'b0, M0, 8'h00, 1'b0, 1'b1);
        step(1'b0, M0, 8'h00, 1'b1, 1'b1);

        // random traffic; producer holds its word until accepted
        hv = 1'b0;
        hd = 1'b0;
        hdata = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(hv && !(rst_n && q.size() < D))) begin
                hv    = ($urandom_range(0, 3) != 0);
                hd    = 1'($urandom_range(0, 1));
                hdata = W'($urandom);
            end
            rr = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 59) != 0);
            step(hv, hd, hdata, rr, rs);
        end

        step(1'b0, M0, 8'h00, 1'b1, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/xbar_ingress_fifo.md
# xbar_ingress_fifo

Per-source ingress queue that sits directly upstream of the 2x2 crossbar, one instance per slave port (s0, s1). It accepts {dst, data} words from a producer over a val/rdy handshake, buffers up to DEPTH of them in order, and presents the head entry to the crossbar as s*_val / s*_dst / s*_data, advancing on s*_rdy. This decouples producers from crossbar arbitration stalls and from destination back-pressure.

## Interface
- WIDTH, 8, data payload width; matches crossbar WIDTH
- DEPTH, 4, number of entries; power of two, >= 2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_val  in  1  producer word valid
- in_dst  in  1  destination master: 0 = m0, 1 = m1
- in_data  in  WIDTH  producer payload
- in_rdy  out  1  queue can accept a word this cycle
- out_val  out  1  head entry valid; drives crossbar s*_val
- out_dst  out  1  head entry destination; drives s*_dst
- out_data  out  WIDTH  head entry payload; drives s*_data
- out_rdy  in  1  crossbar accepts head; from s*_rdy
- count  out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH-entry array of {dst, data}; wr_ptr, rd_ptr each $clog2(DEPTH)+1 bits (extra wrap bit).
- empty = (wr_ptr == rd_ptr); full = index bits equal, wrap bits differ; count = wr_ptr - rd_ptr (modulo 2^(log2 DEPTH+1)).
- push = in_val && in_rdy: write {in_dst, in_data} at wr_ptr index, wr_ptr += 1.
- pop = out_val && out_rdy: rd_ptr += 1.
- in_rdy = !full && rst_n. No pass-through when full: a same-cycle pop does not free a slot for a push in that cycle.
- out_val = !empty; out_dst/out_data = array[rd_ptr index] (read straight from the register array, no output register).
- Push and pop in the same cycle (not full, not empty): both pointers advance, count unchanged.
- Pointer wrap: index rolls DEPTH-1 -> 0, wrap bit toggles; ordering preserved across wrap.
- When empty, out_dst/out_data are don't-care; the bench ignores them.
- Reset (rst_n low at a rising edge): wr_ptr = rd_ptr = 0, discarding all contents, including mid-stream. Array contents are not reset.
- Reset values after the reset edge: out_val 0, count 0, empty 1, full 0, in_rdy 0 while rst_n is low, 1 once rst_n is high.
- Producer rule: in_dst/in_data are held stable while in_val && !in_rdy.
- Guarantee to the crossbar: out_dst/out_data are stable while out_val && !out_rdy.

## Timing
- Latency: word pushed at edge N is visible on out_val/out_data after edge N (usable for pop at edge N+1); one cycle minimum.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- in_rdy, out_val, full, empty, and count depend only on registered pointers (and rst_n for in_rdy), with no combinational path from in_val or out_rdy.
- out_data depends combinationally only on registered state.

## Structure
- xbar_pkg holds:
  - WIDTH default
  - typedef of the flit struct {logic dst; logic [WIDTH-1:0] data}
  - constants M0 = 1'b0, M1 = 1'b1
- Both this block and the crossbar import xbar_pkg.
- One sub-module is natural: xbar_fifo_ctrl, holding pointers, full/empty/count, and push/pop qualification. The storage array lives in the top.
- A wrapper instantiating two queues in front of the crossbar belongs in the integration level, not here.

## Test plan
- Reset then idle: after rst_n low for 1 edge, expect out_val=0, count=0, empty=1, in_rdy=0 during reset and 1 after release.
- Single word: push {dst=1, data=8'h2A} with out_rdy=0; expect out_val=1, out_dst=1, out_data=8'h2A next cycle, held for 3 cycles, popped when out_rdy=1, then empty=1.
- Fill/full: DEPTH=4, push 1,2,3,4 with out_rdy=0; expect full=1, in_rdy=0, count=4. A 5th in_val is not accepted. Drain yields 1,2,3,4 in order.
- Simultaneous push/pop at full: with count=4, in_val=1 and out_rdy=1; expect pop only, count=3, word not taken until the next cycle.
- Wrap-around streaming: in_val=1 and out_rdy=1 continuously for 10 words 0..9; expect output 0..9 in order with no bubble after the first, count steady at 1.
- Reset mid-operation: with count=3, assert rst_n low for one edge; expect count=0, out_val=0, and the next pushed word 8'h55 emerges first.
